ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port 1024 x 10-bit word RAM between two requesters (port 0 = core load/store, port 1 = loader/DMA).
- The RAM has an asynchronous 20-bit pair read, {word[odd], word[even]}, and a synchronous 10-bit write whose half is selected by address[0].
- This block arbitrates between the two ports and sequences each access.
- It splits 20-bit wide writes into two RAM write cycles: even word, then odd word.

Parameters:
- ADDR_W, 10, RAM word-address width.
- WORD_W, 10, RAM word width; the pair/data width is 2*WORD_W.
- FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins ties.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pN_req  in  1  request, N = 0/1; held high until pN_ack.
- pN_we  in  1  1 = write, 0 = read.
- pN_wide  in  1  write only: 1 = write both words of the pair.
- pN_addr  in  ADDR_W  word address.
- pN_wdata  in  2*WORD_W  write data; narrow writes use [WORD_W-1:0].
- pN_ack  out  1  one-cycle completion pulse.
- pN_rdata  out  2*WORD_W  read pair, held until the next read completes on that port.
- ram_we  out  1  to RAM we.
- ram_addr  out  ADDR_W  to RAM address.
- ram_wdata  out  2*WORD_W  to RAM wdata.
- ram_rdata  in  2*WORD_W  from RAM rdata.
- busy  out  1  state != IDLE.
- gnt_id  out  1  port owning the current or most recent transaction.

Behaviour:
- Reset (asynchronous, immediate), all outputs 0:
  - state = IDLE; latched request registers = 0.
  - pN_ack = 0, pN_rdata = 0.
  - ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - busy = 0, gnt_id = 0, last_gnt = 1 (port 0 wins the first tie).
- Reset mid-operation aborts the transaction. ram_we is decoded from state, so it drops asynchronously. No ack is issued. A partially completed wide write leaves only the even word written.
- States: IDLE, RD, WR_LO, WR_HI, ACK.
- IDLE arbitration:
  - Requests are sampled only in IDLE, at the clock edge.
  - One request → grant it.
  - Both requests, FIXED_PRIO = 0 → grant the port != last_gnt.
  - Both requests, FIXED_PRIO = 1 → grant port 0.
  - On grant, latch we, wide, addr, wdata and the port id; update last_gnt and gnt_id.
  - Next state: RD if !we; WR_LO if we.
- RD:
  - ram_addr = latched addr, ram_we = 0.
  - At the edge, ram_rdata is captured into the granted port's pN_rdata. Captured pair = {word[addr|1], word[addr&~1]}.
  - Next state: ACK.
- WR_LO:
  - ram_we = 1.
  - Narrow write: ram_addr = addr; ram_wdata = {wdata[WORD_W-1:0], wdata[WORD_W-1:0]}, so either half selection writes the correct word.
  - Wide write: ram_addr = {addr[ADDR_W-1:1], 0}; ram_wdata = wdata. addr[0] is ignored.
  - Next state: WR_HI if wide, else ACK.
- WR_HI:
  - ram_we = 1, ram_addr = {addr[ADDR_W-1:1], 1}, ram_wdata = wdata. This writes wdata[19:10] into the odd word.
  - Next state: ACK.
- ACK:
  - The granted port's pN_ack = 1 for exactly one cycle; ram_we = 0.
  - Next state: IDLE.
- Latency (req sampled in IDLE at edge T):
  - read or narrow write: ack high in cycle T+2;
  - wide write: ack high in cycle T+3.
  - Read data is valid in the ack cycle.
- Handshake:
  - A requester drops req in the ack cycle to stop.
  - If req is still high in the following IDLE cycle, it is a new transaction. This gives back-to-back throughput of one read per 3 cycles.
- Request changes while a port is not granted or the block is busy are ignored until the next IDLE.
- The losing port is never starved: under round-robin it is guaranteed the next grant.
- Wide write at addr 1023 → words 1022 and 1023 are written; there is no wrap past the top.
- Idle outputs: ram_addr/ram_wdata keep their last values; ram_we = 0.

Test Plan:
- Reset with p0_req held high, then release → first grant goes to port 0. Read addr 10 with RAM words 10 = 5, 11 = 3 → p0_rdata = 20'h00C05 (= {10'd3, 10'd5}), ack at T+2.
- Port 1 narrow write addr 11, wdata[9:0] = 10'h3FD → single ram_we cycle, addr 11, ram_wdata = {3FD, 3FD}. Subsequent read of addr 10 returns {3FD, 005}.
- Port 0 wide write addr 51 (odd), wdata = {10'd7, 10'd9} → ram_we two cycles at addr 50, then 51. Read returns {007, 009}; ack at T+3.
- Both ports request continuously with FIXED_PRIO = 0 → grants alternate 0, 1, 0, 1. Each ack follows its own grant; no double acks.
- FIXED_PRIO = 1, both requesting → port 0 is granted every time while it holds req. Port 1 is granted only in an IDLE cycle where p0_req = 0.
- Assert rst_n = 0 during WR_HI of a wide write → ram_we drops immediately and no ack is issued. After release: state IDLE, outputs 0, odd word unchanged.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter in front of a single-port 1024 x 10-bit RAM with a 20-bit pair read.
// Reads take one RAM cycle. Wide (pair) writes are split into an even-word cycle and then an odd-word cycle.
module ram_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int WORD_W     = 10,
  parameter int FIXED_PRIO = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic                p0_wide,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [2*WORD_W-1:0] p0_wdata,
  output logic                p0_ack,
  output logic [2*WORD_W-1:0] p0_rdata,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic                p1_wide,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [2*WORD_W-1:0] p1_wdata,
  output logic                p1_ack,
  output logic [2*WORD_W-1:0] p1_rdata,
  output logic                ram_we,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [2*WORD_W-1:0] ram_wdata,
  input  logic [2*WORD_W-1:0] ram_rdata,
  output logic                busy,
  output logic                gnt_id
);

  localparam int DATA_W = 2 * WORD_W;

  typedef enum logic [2:0] {IDLE, RD, WR_LO, WR_HI, ACK} state_e;

  state_e              state_q;
  logic                wide_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                id_q;
  logic                last_gnt_q;
  logic [1:0]          ack_q;
  logic [ADDR_W-1:0]   ram_addr_q;
  logic [DATA_W-1:0]   ram_wdata_q;
  logic [DATA_W-1:0]   rdata0_q;
  logic [DATA_W-1:0]   rdata1_q;

  logic                sel_id;
  logic                sel_we;
  logic                sel_wide;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // A single requester wins outright. On a tie, the round-robin mode favours the port that did not win last.
  always_comb begin
    sel_id = p0_req ? 1'b0 : 1'b1;
    if (p0_req && p1_req && (FIXED_PRIO == 0)) sel_id = ~last_gnt_q;
    sel_we    = sel_id ? p1_we    : p0_we;
    sel_wide  = sel_id ? p1_wide  : p0_wide;
    sel_addr  = sel_id ? p1_addr  : p0_addr;
    sel_wdata = sel_id ? p1_wdata : p0_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wide_q      <= 1'b0;
      addr_q      <= '0;
      id_q        <= 1'b0;
      last_gnt_q  <= 1'b1;
      ack_q       <= '0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (p0_req || p1_req) begin
            id_q       <= sel_id;
            last_gnt_q <= sel_id;
            addr_q     <= sel_addr;
            wide_q     <= sel_we & sel_wide;
            if (!sel_we) begin
              state_q    <= RD;
              ram_addr_q <= sel_addr;
            end else if (sel_wide) begin
              state_q     <= WR_LO;
              ram_addr_q  <= {sel_addr[ADDR_W-1:1], 1'b0};
              ram_wdata_q <= sel_wdata;
            end else begin
              // The word is duplicated into both halves, so the RAM's address[0] half-select picks the right one.
              state_q     <= WR_LO;
              ram_addr_q  <= sel_addr;
              ram_wdata_q <= {sel_wdata[WORD_W-1:0], sel_wdata[WORD_W-1:0]};
            end
          end
        end
        RD: begin
          if (id_q) rdata1_q <= ram_rdata;
          else      rdata0_q <= ram_rdata;
          ack_q[id_q] <= 1'b1;
          state_q     <= ACK;
        end
        WR_LO: begin
          if (wide_q) begin
            state_q    <= WR_HI;
            ram_addr_q <= {addr_q[ADDR_W-1:1], 1'b1};
          end else begin
            ack_q[id_q] <= 1'b1;
            state_q     <= ACK;
          end
        end
        WR_HI: begin
          ack_q[id_q] <= 1'b1;
          state_q     <= ACK;
        end
        ACK:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: ram_we is decoded from the state rather than registered, so a reset de-asserts it immediately.
  assign ram_we    = (state_q == WR_LO) || (state_q == WR_HI);
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign busy      = (state_q != IDLE);
  assign gnt_id    = id_q;
  assign p0_ack    = ack_q[0];
  assign p1_ack    = ack_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a round-robin instance backed by a RAM model,
// plus a fixed-priority instance that is used only to observe grant order.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Round-robin instance
  logic        p0_req = 0, p0_we = 0, p0_wide = 0, p1_req = 0, p1_we = 0, p1_wide = 0;
  logic [9:0]  p0_addr = '0, p1_addr = '0;
  logic [19:0] p0_wdata = '0, p1_wdata = '0;
  logic        p0_ack, p1_ack, ram_we, busy, gnt_id;
  logic [19:0] p0_rdata, p1_rdata, ram_wdata, ram_rdata;
  logic [9:0]  ram_addr;

  ram_port_arbiter #(.ADDR_W(10), .WORD_W(10), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_wide(p0_wide), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_wide(p1_wide), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .gnt_id(gnt_id)
  );

  // Fixed-priority instance (its RAM read data is not checked)
  logic        b_p0_req = 0, b_p1_req = 0;
  logic        b_p0_ack, b_p1_ack, b_ram_we, b_busy, b_gnt_id;
  logic [19:0] b_p0_rdata, b_p1_rdata, b_ram_wdata;
  logic [19:0] b_ram_rdata = '0;
  logic [19:0] b_wdata = '0;
  logic [9:0]  b_ram_addr;
  logic [9:0]  b_addr = '0;
  logic        b_low = 1'b0;

  ram_port_arbiter #(.ADDR_W(10), .WORD_W(10), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req(b_p0_req), .p0_we(b_low), .p0_wide(b_low), .p0_addr(b_addr), .p0_wdata(b_wdata),
    .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
    .p1_req(b_p1_req), .p1_we(b_low), .p1_wide(b_low), .p1_addr(b_addr), .p1_wdata(b_wdata),
    .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
    .ram_we(b_ram_we), .ram_addr(b_ram_addr), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata),
    .busy(b_busy), .gnt_id(b_gnt_id)
  );

  // RAM model: asynchronous pair read; synchronous write of the half chosen by address[0]
  logic [9:0] mem [1024];
  logic       pre_en = 1'b0;
  logic [9:0] pre_addr = '0, pre_data = '0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_addr[0] ? ram_wdata[19:10] : ram_wdata[9:0];
  end
  assign ram_rdata = {mem[{ram_addr[9:1], 1'b1}], mem[{ram_addr[9:1], 1'b0}]};

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [9:0] d);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  // Starts at a negedge with the DUT idle. Returns at a negedge after the DUT is back in IDLE.
  // lat counts rising edges from the sampling edge (1) up to the edge that raises ack.
  task automatic txn(input logic port, input logic we, input logic wide, input logic [9:0] addr,
                     input logic [19:0] wdata, output int lat, output int we_cnt,
                     output logic [9:0] wa0, output logic [9:0] wa1, output logic [19:0] wd0,
                     output logic other_ack);
    bit done = 0;
    lat = 0; we_cnt = 0; wa0 = '0; wa1 = '0; wd0 = '0; other_ack = 1'b0;
    if (port) begin p1_req = 1; p1_we = we; p1_wide = wide; p1_addr = addr; p1_wdata = wdata; end
    else      begin p0_req = 1; p0_we = we; p0_wide = wide; p0_addr = addr; p0_wdata = wdata; end
    for (int k = 1; k <= 10 && !done; k++) begin
      @(posedge clk); @(negedge clk);
      if (ram_we) begin
        if (we_cnt == 0) begin wa0 = ram_addr; wd0 = ram_wdata; end
        else wa1 = ram_addr;
        we_cnt++;
      end
      if (port ? p0_ack : p1_ack) other_ack = 1'b1;
      if (port ? p1_ack : p0_ack) begin lat = k; done = 1; end
    end
    p0_req = 0; p1_req = 0;
    @(posedge clk); @(negedge clk);
  endtask

  int          lat, we_cnt, n, dbl;
  logic [9:0]  wa0, wa1;
  logic [19:0] wd0;
  logic        oth, found, seen;
  logic [1:0]  seq [4];

  initial begin
    // Reset, with p0 already requesting a read of address 10
    p0_req = 1; p0_addr = 10'd10; p1_req = 0;
    preload(10'd10, 10'd5);
    preload(10'd11, 10'd3);
    preload(10'd100, 10'd0);
    preload(10'd101, 10'h0AB);
    @(negedge clk);
    check("rst_ram_we", ram_we, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_acks", {p0_ack, p1_ack}, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_rdata", {p0_rdata, p1_rdata}, 0);
    rst_n = 1'b1;

    txn(0, 0, 0, 10'd10, 20'h0, lat, we_cnt, wa0, wa1, wd0, oth);
    check("rd10_lat", lat, 2);
    check("rd10_data", p0_rdata, 20'h00C05);
    check("rd10_gnt", gnt_id, 0);
    check("rd10_other_ack", oth, 0);

    // Narrow write to an odd address: upper wdata bits must not reach the RAM
    txn(1, 1, 0, 10'd11, {10'h155, 10'h3FD}, lat, we_cnt, wa0, wa1, wd0, oth);
    check("nw_lat", lat, 2);
    check("nw_we_cycles", we_cnt, 1);
    check("nw_addr", wa0, 11);
    check("nw_wdata", wd0, {10'h3FD, 10'h3FD});
    check("nw_gnt", gnt_id, 1);
    txn(1, 0, 0, 10'd10, 20'h0, lat, we_cnt, wa0, wa1, wd0, oth);
    check("nw_readback", p1_rdata, {10'h3FD, 10'h005});
    check("nw_p0_rdata_held", p0_rdata, 20'h00C05);

    // Wide write at an odd address: the even word is written first, then the odd word
    txn(0, 1, 1, 10'd51, {10'd7, 10'd9}, lat, we_cnt, wa0, wa1, wd0, oth);
    check("ww_lat", lat, 3);
    check("ww_we_cycles", we_cnt, 2);
    check("ww_addr_lo", wa0, 50);
    check("ww_addr_hi", wa1, 51);
    check("ww_wdata", wd0, {10'd7, 10'd9});
    txn(1, 0, 0, 10'd51, 20'h0, lat, we_cnt, wa0, wa1, wd0, oth);
    check("ww_readback", p1_rdata, {10'd7, 10'd9});

    // Wide write at the top address: words 1022 and 1023, no wrap past the top
    txn(0, 1, 1, 10'd1023, {10'h111, 10'h222}, lat, we_cnt, wa0, wa1, wd0, oth);
    check("top_addr_lo", wa0, 1022);
    check("top_addr_hi", wa1, 1023);
    txn(1, 0, 0, 10'd1022, 20'h0, lat, we_cnt, wa0, wa1, wd0, oth);
    check("top_readback", p1_rdata, {10'h111, 10'h222});

    // Round robin with both ports requesting continuously; last winner was port 1
    p0_req = 1; p0_we = 0; p0_addr = 10'd10;
    p1_req = 1; p1_we = 0; p1_addr = 10'd50;
    n = 0; dbl = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (p0_ack && p1_ack) dbl++;
      else if (p0_ack || p1_ack) begin
        seq[n] = {1'b0, p1_ack};
        check("rr_gnt_matches_ack", gnt_id, p1_ack);
        n++;
      end
    end
    p0_req = 0; p1_req = 0;
    check("rr_ack_count", n, 4);
    check("rr_double_ack", dbl, 0);
    check("rr_seq0", seq[0], 0);
    check("rr_seq1", seq[1], 1);
    check("rr_seq2", seq[2], 0);
    check("rr_seq3", seq[3], 1);
    check("rr_p0_data", p0_rdata, {10'h3FD, 10'h005});
    check("rr_p1_data", p1_rdata, {10'd7, 10'd9});
    @(posedge clk); @(negedge clk);

    // Fixed priority: port 0 wins while it requests; port 1 gets the grant once p0 drops
    b_p0_req = 1; b_p1_req = 1;
    n = 0; dbl = 0;
    for (int k = 0; k < 40 && n < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (b_p0_ack && b_p1_ack) dbl++;
      else if (b_p0_ack || b_p1_ack) begin
        seq[n] = {1'b0, b_p1_ack};
        n++;
        if (n == 3) b_p0_req = 0;
      end
    end
    b_p0_req = 0; b_p1_req = 0;
    check("fp_ack_count", n, 4);
    check("fp_double_ack", dbl, 0);
    check("fp_seq0", seq[0], 0);
    check("fp_seq1", seq[1], 0);
    check("fp_seq2", seq[2], 0);
    check("fp_seq3", seq[3], 1);
    @(posedge clk); @(negedge clk);

    // Reset during WR_HI of a wide write to 100/101
    p0_req = 1; p0_we = 1; p0_wide = 1; p0_addr = 10'd100; p0_wdata = {10'h2AA, 10'h155};
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk); @(negedge clk);
      if (ram_we && ram_addr == 10'd101) found = 1;
    end
    check("mid_rst_reached_wr_hi", found, 1);
    #1 rst_n = 1'b0;
    p0_req = 0;
    #1;
    check("mid_rst_we_drops", ram_we, 0);
    check("mid_rst_busy", busy, 0);
    seen = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      if (p0_ack || p1_ack) seen = 1;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); @(negedge clk);
      if (p0_ack || p1_ack) seen = 1;
    end
    check("mid_rst_no_ack", seen, 0);
    check("post_rst_busy", busy, 0);
    check("post_rst_gnt", gnt_id, 0);
    check("post_rst_ram_addr", ram_addr, 0);
    check("post_rst_ram_wdata", ram_wdata, 0);
    check("post_rst_rdata", {p0_rdata, p1_rdata}, 0);
    check("post_rst_even_word", mem[100], 10'h155);
    check("post_rst_odd_word", mem[101], 10'h0AB);

    // After reset the first tie goes to port 0 again
    p0_req = 1; p0_we = 0; p0_wide = 0; p0_addr = 10'd100;
    p1_req = 1; p1_we = 0; p1_wide = 0; p1_addr = 10'd10;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(posedge clk); @(negedge clk);
      if (p0_ack || p1_ack) begin
        found = 1;
        check("post_rst_tie_p0", {p1_ack, p0_ack}, 2'b01);
      end
    end
    p0_req = 0; p1_req = 0;
    check("post_rst_tie_ack_seen", found, 1);
    check("post_rst_tie_data", p0_rdata, {10'h0AB, 10'h155});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
